// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: services a cache miss by optionally writing back a dirty victim and then refilling the missing line.
// Latency: refill_valid_o 2 cycles after a clean-miss accept edge and 3 after a dirty one, plus any memory wait cycles.
// Backpressure: holds each memory request until mem_valid_i; misses are ignored while busy. CACHE_MEM_TIMEOUT_EN adds an abort after TIMEOUT_CYC waits.
module cache_mem_ctrl #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         miss_i,
    input  logic [31:0]  miss_addr_i,
    input  logic         dirty_i,
    input  logic [31:0]  victim_addr_i,
    input  logic [127:0] victim_data_i,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_dataW_o,
    output logic         mem_rw_o,
    output logic         mem_req_valid_o,
    input  logic [127:0] mem_dataR_i,
    input  logic         mem_valid_i,
    output logic [127:0] refill_data_o,
    output logic         refill_valid_o,
    output logic         busy_o,
    output logic         error_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RF   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [27:0]   r_miss_line;
    logic [27:0]   r_victim_line;
    logic [127:0]  r_victim_data;
    logic [127:0]  r_refill_data;
    logic          w_timeout;
    logic          w_accept;
    logic          w_unused;

    // Byte-offset bits are never used: every transfer is a whole line.
    assign w_unused = ^{miss_addr_i[3:0], victim_addr_i[3:0], (TIMEOUT_CYC != 0)};
    assign w_accept = (r_state == S_IDLE) && miss_i;

`ifdef CACHE_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_wait_cnt;
    logic          r_error;

    // Wait counter: restarts on every state change, otherwise counts stalled memory cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= '0;
        end else if (w_next != r_state) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WB || r_state == S_RF) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WB || r_state == S_RF) && !mem_valid_i
                       && (r_wait_cnt == CW'(TIMEOUT_CYC - 1));

    // Error strobe lands in the IDLE cycle that follows the abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_timeout;
        end
    end

    assign error_o = r_error;
`else
    assign w_timeout = 1'b0;
    assign error_o   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the miss context on accept; capture refill data when the read completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_miss_line   <= '0;
            r_victim_line <= '0;
            r_victim_data <= '0;
            r_refill_data <= '0;
        end else begin
            if (w_accept) begin
                r_miss_line   <= miss_addr_i[31:4];
                r_victim_line <= victim_addr_i[31:4];
                r_victim_data <= victim_data_i;
            end
            if (r_state == S_RF && mem_valid_i) begin
                r_refill_data <= mem_dataR_i;
            end
        end
    end

    assign refill_data_o = r_refill_data;

    // Next-state and memory-side outputs; completion is only sampled in WB/RF.
    always_comb begin
        w_next          = r_state;
        mem_req_valid_o = 1'b0;
        mem_rw_o        = 1'b0;
        mem_addr_o      = '0;
        mem_dataW_o     = '0;
        refill_valid_o  = 1'b0;
        busy_o          = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (miss_i) begin
                    w_next = dirty_i ? S_WB : S_RF;
                end
            end
            S_WB: begin
                mem_req_valid_o = 1'b1;
                mem_rw_o        = 1'b1;
                mem_addr_o      = {r_victim_line, 4'h0};
                mem_dataW_o     = r_victim_data;
                if (w_timeout) begin
                    w_next = S_IDLE;
                end else if (mem_valid_i) begin
                    w_next = S_RF;
                end
            end
            S_RF: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = {r_miss_line, 4'h0};
                if (w_timeout) begin
                    w_next = S_IDLE;
                end else if (mem_valid_i) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                refill_valid_o = 1'b1;
                w_next         = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: directed literal checks plus randomized traffic against a queue-of-pending-work model.
// Latency: model and DUT advance on the same clock edge; outputs compared on every falling edge.
// Backpressure: mem_valid_i is randomized, with stretches of heavy stalling to reach the wait/abort paths.
`timescale 1ns/1ps
module tb_cache_mem_ctrl;

    localparam int TO = 15;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         miss_i = 1'b0;
    logic [31:0]  miss_addr_i = '0;
    logic         dirty_i = 1'b0;
    logic [31:0]  victim_addr_i = '0;
    logic [127:0] victim_data_i = '0;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_dataW_o;
    logic         mem_rw_o;
    logic         mem_req_valid_o;
    logic [127:0] mem_dataR_i = '0;
    logic         mem_valid_i = 1'b0;
    logic [127:0] refill_data_o;
    logic         refill_valid_o;
    logic         busy_o;
    logic         error_o;

    always #5 clk_i = ~clk_i;

    cache_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .miss_i          (miss_i),
        .miss_addr_i     (miss_addr_i),
        .dirty_i         (dirty_i),
        .victim_addr_i   (victim_addr_i),
        .victim_data_i   (victim_data_i),
        .mem_addr_o      (mem_addr_o),
        .mem_dataW_o     (mem_dataW_o),
        .mem_rw_o        (mem_rw_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_dataR_i     (mem_dataR_i),
        .mem_valid_i     (mem_valid_i),
        .refill_data_o   (refill_data_o),
        .refill_valid_o  (refill_valid_o),
        .busy_o          (busy_o),
        .error_o         (error_o)
    );

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is a list of pending jobs (write-back, read, response strobe).
    typedef enum int {OP_WR, OP_RD, OP_RESP} op_e;
    op_e          m_q[$];
    logic [31:0]  m_maddr = '0;
    logic [31:0]  m_vaddr = '0;
    logic [127:0] m_vdata = '0;
    logic [127:0] m_refill = '0;
    logic         m_err = 1'b0;
    int           m_wait = 0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q.delete();
            m_maddr  <= '0;
            m_vaddr  <= '0;
            m_vdata  <= '0;
            m_refill <= '0;
            m_err    <= 1'b0;
            m_wait   <= 0;
        end else begin
            m_err <= 1'b0;
            if (m_q.size() == 0) begin
                if (miss_i) begin
                    m_maddr <= miss_addr_i & 32'hFFFF_FFF0;
                    m_vaddr <= victim_addr_i & 32'hFFFF_FFF0;
                    m_vdata <= victim_data_i;
                    if (dirty_i) m_q.push_back(OP_WR);
                    m_q.push_back(OP_RD);
                    m_q.push_back(OP_RESP);
                    m_wait <= 0;
                end
            end else if (m_q[0] == OP_RESP) begin
                void'(m_q.pop_front());
            end else if (mem_valid_i) begin
                if (m_q[0] == OP_RD) m_refill <= mem_dataR_i;
                void'(m_q.pop_front());
                m_wait <= 0;
            end else begin
                m_wait <= m_wait + 1;
`ifdef CACHE_MEM_TIMEOUT_EN
                if (m_wait + 1 == TO) begin
                    m_q.delete();
                    m_err  <= 1'b1;
                    m_wait <= 0;
                end
`endif
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against what the pending-job list implies.
    always @(negedge clk_i) begin
        int hd;
        logic [31:0]  e_addr;
        logic [127:0] e_dw;
        if (chk_en) begin
            hd = (m_q.size() != 0) ? int'(m_q[0]) : -1;
            e_addr = (hd == int'(OP_WR)) ? m_vaddr : (hd == int'(OP_RD)) ? m_maddr : 32'h0;
            e_dw   = (hd == int'(OP_WR)) ? m_vdata : 128'h0;
            chk("busy", {127'h0, busy_o}, {127'h0, m_q.size() != 0});
            chk("req_valid", {127'h0, mem_req_valid_o}, {127'h0, (hd == int'(OP_WR)) || (hd == int'(OP_RD))});
            chk("rw", {127'h0, mem_rw_o}, {127'h0, hd == int'(OP_WR)});
            chk("mem_addr", {96'h0, mem_addr_o}, {96'h0, e_addr});
            chk("mem_dataW", mem_dataW_o, e_dw);
            chk("refill_valid", {127'h0, refill_valid_o}, {127'h0, hd == int'(OP_RESP)});
            chk("refill_data", refill_data_o, m_refill);
            chk("error", {127'h0, error_o}, {127'h0, m_err});
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"}, {127'h0, busy_o}, 128'h0);
        chk({tag, "_req"}, {127'h0, mem_req_valid_o}, 128'h0);
        chk({tag, "_rv"}, {127'h0, refill_valid_o}, 128'h0);
        chk({tag, "_addr"}, {96'h0, mem_addr_o}, 128'h0);
    endtask

    initial begin
        int vp;
        // Reset state
        step();
        chk_en = 1'b1;
        step();
        chk_idle_outs("rst");
        chk("rst_rdata", refill_data_o, 128'h0);
        chk("rst_err", {127'h0, error_o}, 128'h0);
        rst_ni = 1'b1;

        // Clean miss, memory ready on the accept edge too
        miss_i = 1'b1; dirty_i = 1'b0; miss_addr_i = 32'h0000_0804;
        mem_valid_i = 1'b1; mem_dataR_i = {16{8'hA5}};
        step();
        miss_i = 1'b0;
        chk("c_req", {127'h0, mem_req_valid_o}, 128'h1);
        chk("c_rw", {127'h0, mem_rw_o}, 128'h0);
        chk("c_addr", {96'h0, mem_addr_o}, 128'h800);
        chk("c_rv0", {127'h0, refill_valid_o}, 128'h0);
        step();
        chk("c_rv", {127'h0, refill_valid_o}, 128'h1);
        chk("c_rdata", refill_data_o, {16{8'hA5}});
        chk("c_req1", {127'h0, mem_req_valid_o}, 128'h0);
        step();
        chk_idle_outs("c_end");
        chk("c_hold", refill_data_o, {16{8'hA5}});

        // Dirty miss: write-back then refill
        miss_i = 1'b1; dirty_i = 1'b1; miss_addr_i = 32'h0000_0800;
        victim_addr_i = 32'h0000_0C00; victim_data_i = {32{4'h1}};
        mem_dataR_i = {32{4'h2}};
        step();
        miss_i = 1'b0;
        chk("d_wb_rw", {127'h0, mem_rw_o}, 128'h1);
        chk("d_wb_addr", {96'h0, mem_addr_o}, 128'hC00);
        chk("d_wb_data", mem_dataW_o, {32{4'h1}});
        step();
        chk("d_rf_rw", {127'h0, mem_rw_o}, 128'h0);
        chk("d_rf_addr", {96'h0, mem_addr_o}, 128'h800);
        chk("d_rf_dw", mem_dataW_o, 128'h0);
        step();
        chk("d_rv", {127'h0, refill_valid_o}, 128'h1);
        chk("d_rdata", refill_data_o, {32{4'h2}});
        step();

        // Stalled refill: five cycles without a response
        miss_i = 1'b1; dirty_i = 1'b0; miss_addr_i = 32'h1234_567F;
        mem_valid_i = 1'b0; mem_dataR_i = {32{4'h3}};
        step();
        miss_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("s_req", {127'h0, mem_req_valid_o}, 128'h1);
            chk("s_addr", {96'h0, mem_addr_o}, 128'h1234_5670);
            step();
        end
        chk("s_rv0", {127'h0, refill_valid_o}, 128'h0);
        mem_valid_i = 1'b1;
        step();
        chk("s_rv", {127'h0, refill_valid_o}, 128'h1);
        chk("s_rdata", refill_data_o, {32{4'h3}});
        step();

        // Reset in the middle of a write-back
        miss_i = 1'b1; dirty_i = 1'b1; mem_valid_i = 1'b0;
        step();
        miss_i = 1'b0;
        chk("r_wb", {127'h0, mem_req_valid_o & mem_rw_o}, 128'h1);
        #2 rst_ni = 1'b0;
        #1;
        chk_idle_outs("r_now");
        chk("r_rdata", refill_data_o, 128'h0);
        chk("r_dw", mem_dataW_o, 128'h0);
        step();
        rst_ni = 1'b1; mem_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle_outs("r_after");
        end

        // Miss held high: one IDLE cycle between back-to-back services
        miss_i = 1'b1; dirty_i = 1'b0; mem_valid_i = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("b2b_busy", {127'h0, busy_o}, {127'h0, (i % 3) != 2});
            chk("b2b_rv", {127'h0, refill_valid_o}, {127'h0, (i % 3) == 1});
            if (i == 5) miss_i = 1'b0;
            else step();
        end
        step();

`ifdef CACHE_MEM_TIMEOUT_EN
        // Abort after TO stalled refill cycles
        miss_i = 1'b1; dirty_i = 1'b0; mem_valid_i = 1'b0;
        step();
        miss_i = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("t_req", {127'h0, mem_req_valid_o}, 128'h1);
            chk("t_err0", {127'h0, error_o}, 128'h0);
            step();
        end
        chk("t_err", {127'h0, error_o}, 128'h1);
        chk_idle_outs("t_idle");
        step();
        chk("t_err1", {127'h0, error_o}, 128'h0);
`endif

        // Randomized traffic, alternating light and heavy memory stalls, rare resets
        for (int c = 0; c < 3000; c++) begin
            vp = ((c / 250) % 2) != 0 ? 1 : 6;
            miss_i        = ($urandom_range(0, 3) == 0);
            dirty_i       = $urandom_range(0, 1) != 0;
            miss_addr_i   = $urandom;
            victim_addr_i = $urandom;
            victim_data_i = {$urandom, $urandom, $urandom, $urandom};
            mem_dataR_i   = {$urandom, $urandom, $urandom, $urandom};
            mem_valid_i   = ($urandom_range(0, 9) < vp);
            rst_ni        = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_ni = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_mem_ctrl.md
CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk_i (rising edge) and rst_ni.
REQ-002 The block SHALL have one parameter, TIMEOUT_CYC, default 15: the number of wait cycles before a memory request is aborted (used only under REQ-030).
REQ-003 The block SHALL have the following ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- miss_i  in  1  cache requests miss service
- miss_addr_i  in  32  byte address of the missing line
- dirty_i  in  1  victim line is dirty
- victim_addr_i  in  32  byte address of the victim line
- victim_data_i  in  128  victim line data
- mem_addr_o  out  32  memory byte address, bits [3:0] always 0
- mem_dataW_o  out  128  write line to memory
- mem_rw_o  out  1  1=write, 0=read
- mem_req_valid_o  out  1  memory request valid
- mem_dataR_i  in  128  read line from memory
- mem_valid_i  in  1  memory response valid
- refill_data_o  out  128  refilled line to cache
- refill_valid_o  out  1  one-cycle refill strobe
- busy_o  out  1  controller not IDLE
- error_o  out  1  one-cycle timeout strobe

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, WB, RF and RESP.
REQ-005 In IDLE with miss_i=1 at a clock edge, the block SHALL latch miss_addr_i[31:4], victim_addr_i[31:4] and victim_data_i, and go to WB if dirty_i=1, else to RF.
REQ-006 In IDLE, the block SHALL hold mem_req_valid_o=0 and busy_o=0.
REQ-007 In WB, the block SHALL drive mem_req_valid_o=1, mem_rw_o=1, mem_addr_o={victim_addr[31:4],4'h0} and mem_dataW_o=latched victim data.
REQ-008 In WB, mem_valid_i=1 at an edge SHALL complete the write and move the FSM to RF.
REQ-009 In RF, the block SHALL drive mem_req_valid_o=1, mem_rw_o=0 and mem_addr_o={miss_addr[31:4],4'h0}.
REQ-010 In RF, mem_valid_i=1 at an edge SHALL register mem_dataR_i into refill_data_o and move the FSM to RESP.
REQ-011 In RESP, the block SHALL drive refill_valid_o=1 for exactly one cycle and then return to IDLE.
REQ-012 refill_data_o SHALL hold its value until the next refill capture.
REQ-013 busy_o SHALL be 1 in WB, RF and RESP.
REQ-014 miss_i SHALL be ignored outside IDLE; a miss still asserted during RESP SHALL be accepted in the following IDLE cycle.
REQ-015 Latency, with mem_valid_i held high: a clean miss SHALL give refill_valid_o 2 cycles after the accept edge; a dirty miss SHALL give it 3 cycles after.
REQ-016 Outside WB and RF, the block SHALL drive mem_req_valid_o=0, mem_rw_o=0 and mem_addr_o/mem_dataW_o=0.
REQ-017 Address inputs SHALL be line-aligned internally; input bits [3:0] SHALL be ignored.
REQ-018 If mem_valid_i=1 on the same edge that a miss is accepted, it SHALL NOT complete the new request; completion SHALL be sampled only while in WB or RF.

Reset
REQ-019 While rst_ni=0, the block SHALL immediately force state=IDLE and all outputs and registers to 0.
REQ-020 Reset during WB, RF or RESP SHALL abort the transaction silently, with no refill_valid_o and no error_o.

Configuration
REQ-030 With CACHE_MEM_TIMEOUT_EN defined, a counter SHALL count consecutive WB/RF cycles without mem_valid_i; on reaching TIMEOUT_CYC, the FSM SHALL go to IDLE, error_o SHALL pulse for one cycle and refill_valid_o SHALL stay 0.
REQ-031 The timeout counter SHALL clear on every state change.
REQ-032 Without CACHE_MEM_TIMEOUT_EN, the counter SHALL be absent, error_o SHALL be tied to 0, and WB/RF SHALL wait indefinitely.

Verification
REQ-040 Clean miss, addr 0x0000_0804, mem_valid_i=1, mem_dataR_i=0xA5..A5 -> one RF cycle at address 0x0000_0800 with rw=0; refill_valid_o pulses 2 cycles after accept with data 0xA5..A5.
REQ-041 Dirty miss, victim 0x0000_0C00 with data 0x1111..., miss 0x0000_0800 -> WB cycle (rw=1, 0x0C00, 0x1111...), then RF cycle at 0x0800, then refill_valid_o.
REQ-042 mem_valid_i held 0 for 5 cycles in RF -> mem_req_valid_o stays 1 with stable address; refill follows 1 cycle after mem_valid_i rises.
REQ-043 rst_ni pulled low mid-WB -> all outputs 0 immediately; no refill_valid_o after release.
REQ-044 With CACHE_MEM_TIMEOUT_EN and TIMEOUT_CYC=15, mem_valid_i=0 -> error_o pulses once after 15 RF cycles, FSM returns to IDLE, refill_valid_o stays 0.
REQ-045 miss_i held high continuously -> back-to-back services with exactly one IDLE cycle between RESP and the next WB/RF.
